// File: rtl/vmem_port_arbiter.sv
// Burst-level round-robin arbiter sharing the vector-memory queue port between
// the vector load/store unit (client 0) and the scalar bulk copy engine (client 1).
module vmem_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c0_req,
    input  logic                      c0_is_store,
    input  logic [ADDR_WIDTH-1:0]     c0_addr,
    input  logic [LEN_WIDTH-1:0]      c0_len,
    output logic                      c0_ack,
    input  logic [DATA_WIDTH-1:0]     c0_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   c0_wr_be,
    input  logic                      c0_wr_valid,
    output logic                      c0_wr_ready,
    output logic [DATA_WIDTH-1:0]     c0_rd_data,
    output logic                      c0_rd_valid,
    output logic                      c0_done,
    input  logic                      c1_req,
    input  logic                      c1_is_store,
    input  logic [ADDR_WIDTH-1:0]     c1_addr,
    input  logic [LEN_WIDTH-1:0]      c1_len,
    output logic                      c1_ack,
    input  logic [DATA_WIDTH-1:0]     c1_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   c1_wr_be,
    input  logic                      c1_wr_valid,
    output logic                      c1_wr_ready,
    output logic [DATA_WIDTH-1:0]     c1_rd_data,
    output logic                      c1_rd_valid,
    output logic                      c1_done,
    output logic                      mq_start,
    output logic                      mq_is_store,
    output logic [ADDR_WIDTH-1:0]     mq_addr,
    output logic [LEN_WIDTH-1:0]      mq_len,
    output logic [DATA_WIDTH-1:0]     mq_wr_data,
    output logic [DATA_WIDTH/8-1:0]   mq_wr_be,
    output logic                      mq_wr_valid,
    input  logic                      mq_wr_ready,
    input  logic [DATA_WIDTH-1:0]     mq_rd_data,
    input  logic                      mq_rd_valid,
    input  logic                      mq_done_ld,
    input  logic                      mq_done_st,
    output logic                      err
);
    typedef enum logic [1:0] {IDLE, START, XFER, FIN} state_t;

    state_t                  r_state, w_state_next;
    logic                    r_gnt, r_ptr, r_is_store, r_err;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]    r_len, r_count;

    logic                    w_win_valid, w_win, w_req_store;
    logic [ADDR_WIDTH-1:0]   w_req_addr;
    logic [LEN_WIDTH-1:0]    w_req_len, w_count_next;
    logic                    w_ld, w_st, w_room, w_beat, w_done_match, w_done_wrong, w_err_set;
    logic                    w_g_wr_valid;
    logic [DATA_WIDTH-1:0]   w_g_wr_data;
    logic [DATA_WIDTH/8-1:0] w_g_wr_be;

    // Pointer names the preferred client only when both request at once.
    assign w_win_valid = !reset && (c0_req || c1_req);
    assign w_win       = (c0_req && c1_req) ? r_ptr : c1_req;
    assign w_req_store = w_win ? c1_is_store : c0_is_store;
    assign w_req_addr  = w_win ? c1_addr : c0_addr;
    assign w_req_len   = w_win ? c1_len : c0_len;

    assign w_ld         = (r_state == XFER) && !r_is_store;
    assign w_st         = (r_state == XFER) && r_is_store;
    assign w_room       = (r_count != r_len);
    assign w_g_wr_valid = r_gnt ? c1_wr_valid : c0_wr_valid;
    assign w_g_wr_data  = r_gnt ? c1_wr_data : c0_wr_data;
    assign w_g_wr_be    = r_gnt ? c1_wr_be : c0_wr_be;
    assign w_beat       = w_ld ? (mq_rd_valid && w_room)
                               : (w_st && w_room && w_g_wr_valid && mq_wr_ready);
    assign w_count_next = r_count + {{(LEN_WIDTH-1){1'b0}}, w_beat};
    assign w_done_match = r_is_store ? mq_done_st : mq_done_ld;
    assign w_done_wrong = r_is_store ? mq_done_ld : mq_done_st;

    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        c0_ack       = 1'b0;
        c1_ack       = 1'b0;
        c0_wr_ready  = 1'b0;
        c1_wr_ready  = 1'b0;
        c0_rd_data   = '0;
        c1_rd_data   = '0;
        c0_rd_valid  = 1'b0;
        c1_rd_valid  = 1'b0;
        c0_done      = 1'b0;
        c1_done      = 1'b0;
        mq_start     = 1'b0;
        mq_is_store  = r_is_store;
        mq_addr      = r_addr;
        mq_len       = r_len;
        mq_wr_data   = '0;
        mq_wr_be     = '0;
        mq_wr_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_err_set = mq_rd_valid || mq_done_ld || mq_done_st;
                if (w_win_valid) begin
                    c0_ack       = !w_win;
                    c1_ack       = w_win;
                    w_state_next = (w_req_len == '0) ? FIN : START;
                end
            end
            START: begin
                mq_start     = 1'b1;
                w_state_next = XFER;
            end
            XFER: begin
                if (r_is_store) begin
                    mq_wr_valid = w_room && w_g_wr_valid;
                    mq_wr_data  = w_g_wr_data;
                    mq_wr_be    = w_g_wr_be;
                    c0_wr_ready = !r_gnt && w_room && mq_wr_ready;
                    c1_wr_ready = r_gnt && w_room && mq_wr_ready;
                end else begin
                    c0_rd_valid = !r_gnt && mq_rd_valid && w_room;
                    c1_rd_valid = r_gnt && mq_rd_valid && w_room;
                    c0_rd_data  = r_gnt ? '0 : mq_rd_data;
                    c1_rd_data  = r_gnt ? mq_rd_data : '0;
                    w_err_set   = mq_rd_valid && !w_room;
                end
                // A done that lands with the final beat counts that beat first.
                if (w_done_match) begin
                    w_state_next = FIN;
                    if (w_count_next != r_len) w_err_set = 1'b1;
                end
                if (w_done_wrong) w_err_set = 1'b1;
            end
            FIN: begin
                c0_done      = !r_gnt;
                c1_done      = r_gnt;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= 1'b0;
            r_ptr      <= 1'b0;
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_err_set) r_err <= 1'b1;
            if (r_state == IDLE && w_win_valid) begin
                r_gnt      <= w_win;
                r_ptr      <= !w_win;
                r_is_store <= w_req_store;
                r_addr     <= w_req_addr;
                r_len      <= w_req_len;
                r_count    <= '0;
            end else if (w_beat) begin
                r_count <= w_count_next;
            end
        end
    end

    assign err = r_err;
endmodule
